// File: rtl/sha256_padder.sv
// sha256_padder: AXI-stream front end for sha256_main.
// Forwards raw big-endian message words, then appends the SHA-256 padding
// (0x80 marker, zero fill, 64-bit bit length) and flags word 15 of the final
// 512-bit block with m_axis_tlast.
module sha256_padder #(
    parameter int LEN_W = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] s_axis_tdata,
    input  logic [3:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready
);

    typedef enum logic [2:0] {
        DATA  = 3'd0,
        MARK  = 3'd1,
        ZERO  = 3'd2,
        LENHI = 3'd3,
        LENLO = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  widx_reg, widx_next;
    logic [60:0] bytes_reg, bytes_next;
    logic [31:0] tdata_reg, tdata_next;
    logic        tvalid_reg, tvalid_next;
    logic        tlast_reg, tlast_next;

    logic             ld;
    logic [2:0]       kcnt;
    logic [31:0]      marked;
    logic [3:0]       widx_inc;
    logic [LEN_W-1:0] bit_len;

    // The output register may take a new word when empty or being drained.
    assign ld            = !tvalid_reg || m_axis_tready;
    // Gated with resetn so every output reads 0 while reset is held.
    assign s_axis_tready = resetn && (state_reg == DATA) && ld;

    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tvalid = tvalid_reg;
    assign m_axis_tlast  = tlast_reg;

    assign widx_inc = widx_reg + 4'd1;
    assign bit_len  = LEN_W'({bytes_reg, 3'b000});

    // Valid byte count of a final beat: leading ones of tkeep starting at bit3.
    always_comb begin
        if (!s_axis_tkeep[3])      kcnt = 3'd0;
        else if (!s_axis_tkeep[2]) kcnt = 3'd1;
        else if (!s_axis_tkeep[1]) kcnt = 3'd2;
        else if (!s_axis_tkeep[0]) kcnt = 3'd3;
        else                       kcnt = 3'd4;
    end

    // Final partial word: keep the valid bytes, put 0x80 right after them,
    // clear everything behind the marker (byte 0 is [31:24]).
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        localparam int         HI  = 31 - 8 * gi;
        localparam logic [2:0] IDX = 3'(gi);
        assign marked[HI -: 8] = (IDX < kcnt)  ? s_axis_tdata[HI -: 8] :
                                 (IDX == kcnt) ? 8'h80 : 8'h00;
    end

    // Next-state and next-output-word logic; everything advances only on ld.
    always_comb begin
        state_next  = state_reg;
        widx_next   = widx_reg;
        bytes_next  = bytes_reg;
        tdata_next  = tdata_reg;
        tvalid_next = tvalid_reg;
        tlast_next  = tlast_reg;
        if (ld) begin
            tvalid_next = 1'b0;
            tlast_next  = 1'b0;
            unique case (state_reg)
                DATA: begin
                    if (s_axis_tvalid) begin
                        tvalid_next = 1'b1;
                        widx_next   = widx_inc;
                        if (!s_axis_tlast) begin
                            tdata_next = s_axis_tdata;
                            bytes_next = bytes_reg + 61'd4;
                        end else begin
                            bytes_next = bytes_reg + 61'(kcnt);
                            if (kcnt == 3'd4) begin
                                tdata_next = s_axis_tdata;
                                state_next = MARK;
                            end else begin
                                tdata_next = marked;
                                // Marker landed on word 13: no zero fill needed.
                                state_next = (widx_inc == 4'd14) ? LENHI : ZERO;
                            end
                        end
                    end
                end
                MARK: begin
                    tdata_next  = 32'h8000_0000;
                    tvalid_next = 1'b1;
                    widx_next   = widx_inc;
                    state_next  = (widx_inc == 4'd14) ? LENHI : ZERO;
                end
                ZERO: begin
                    tdata_next  = 32'h0;
                    tvalid_next = 1'b1;
                    widx_next   = widx_inc;
                    state_next  = (widx_inc == 4'd14) ? LENHI : ZERO;
                end
                LENHI: begin
                    tdata_next  = bit_len[63:32];
                    tvalid_next = 1'b1;
                    widx_next   = widx_inc;
                    state_next  = LENLO;
                end
                LENLO: begin
                    tdata_next  = bit_len[31:0];
                    tvalid_next = 1'b1;
                    tlast_next  = 1'b1;
                    widx_next   = 4'd0;
                    bytes_next  = 61'd0;
                    state_next  = DATA;
                end
                default: begin
                    state_next = DATA;
                end
            endcase
        end
    end

    // State, counters and the single output register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= DATA;
            widx_reg   <= 4'd0;
            bytes_reg  <= 61'd0;
            tdata_reg  <= 32'h0;
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            widx_reg   <= widx_next;
            bytes_reg  <= bytes_next;
            tdata_reg  <= tdata_next;
            tvalid_reg <= tvalid_next;
            tlast_reg  <= tlast_next;
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: table of messages driven through the padder; a byte-level
// SHA-256 padding model fills a scoreboard queue that is checked word by word.
module tb_sha256_padder;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic [3:0]  s_axis_tkeep = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;

    always #5 clk = ~clk;

    sha256_padder #(.LEN_W(64)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } word_t;

    typedef struct {
        int          len;
        int          kind;       // 0 "abc", 1 NIST 56-byte, 2 counting pattern
        bit          junk;       // garbage in unused bytes, full-beat tlast
        bit          bp;         // random downstream backpressure
        int          exp_nwords;
        logic [31:0] exp_lenlo;
    } vec_t;

    beat_t       beats[$];
    word_t       expq[$];
    int          res_n[$];
    logic [31:0] res_last[$];
    int          vectors = 0;
    int          errors = 0;

    function automatic logic [7:0] msg_byte(input int kind, input int i);
        case (kind)
            0:       return 8'(32'h61 + i);
            1:       return 8'(32'h61 + i / 4 + i % 4);
            default: return 8'(i * 7 + 3);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", name, got, exp);
        end
    endtask

    // Queue the input beats for one message and its padded words from the model.
    task automatic add_msg(input int len, input int kind, input bit junk);
        logic [7:0]  p[$];
        beat_t       b;
        word_t       w;
        int          r;
        int          nw;
        logic [63:0] bl;
        for (int i = 0; i < len; i++) p.push_back(msg_byte(kind, i));
        for (int i = 0; i < len / 4; i++) begin
            b.data = {p[4*i], p[4*i+1], p[4*i+2], p[4*i+3]};
            b.keep = (i % 3 == 1) ? 4'b0000 : ((i % 3 == 2) ? 4'b0110 : 4'b1111);
            b.last = 1'b0;
            beats.push_back(b);
        end
        r = len % 4;
        if (r == 0 && junk && len > 0) begin
            b = beats.pop_back();
            b.keep = 4'b1111;
            b.last = 1'b1;
            beats.push_back(b);
        end else begin
            b.data = junk ? 32'hdead_beef : 32'h0;
            for (int j = 0; j < r; j++) b.data[31-8*j -: 8] = p[4*(len/4)+j];
            b.keep = 4'(4'b1111 << (4 - r));
            b.last = 1'b1;
            beats.push_back(b);
        end
        bl = 64'(len) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int j = 7; j >= 0; j--) p.push_back(bl[8*j +: 8]);
        nw = p.size() / 4;
        for (int i = 0; i < nw; i++) begin
            w.data = {p[4*i], p[4*i+1], p[4*i+2], p[4*i+3]};
            w.last = (i == nw - 1);
            expq.push_back(w);
        end
    endtask

    // Drive queued beats and check outputs at negedge+1; stops early after
    // max_acc accepted beats when max_acc > 0.
    task automatic run(input bit bp, input int max_acc);
        int    cyc = 0;
        int    n_acc = 0;
        int    cnt = 0;
        bit    have = 0;
        bit    acc = 0;
        bit    in_pad = 0;
        beat_t cur = '0;
        while ((beats.size() > 0 || have || expq.size() > 0) && cyc < 3000) begin
            @(negedge clk);
            if (acc) begin
                have = 0;
                acc  = 0;
            end
            if (!have && beats.size() > 0) begin
                cur  = beats.pop_front();
                have = 1;
            end
            s_axis_tvalid = have;
            s_axis_tdata  = have ? cur.data : 32'h0;
            s_axis_tkeep  = have ? cur.keep : 4'h0;
            s_axis_tlast  = have && cur.last;
            m_axis_tready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (m_axis_tvalid) begin
                vectors++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL extra_word: got %08h, expected no output", m_axis_tdata);
                end else begin
                    if (m_axis_tdata !== expq[0].data || m_axis_tlast !== expq[0].last) begin
                        errors++;
                        $display("FAIL word%0d: got %08h last=%0b, expected %08h last=%0b",
                                 cnt, m_axis_tdata, m_axis_tlast, expq[0].data, expq[0].last);
                    end
                    if (m_axis_tready) begin
                        cnt++;
                        if (expq[0].last) begin
                            res_n.push_back(cnt);
                            res_last.push_back(m_axis_tdata);
                            cnt    = 0;
                            in_pad = 0;
                        end
                        void'(expq.pop_front());
                    end
                end
            end
            if (in_pad) begin
                vectors++;
                if (s_axis_tready !== 1'b0) begin
                    errors++;
                    $display("FAIL tready_in_pad: got %0b, expected 0", s_axis_tready);
                end
            end
            if (have && s_axis_tready) begin
                acc = 1;
                n_acc++;
                if (cur.last) in_pad = 1;
            end
            cyc++;
            if (max_acc > 0 && n_acc >= max_acc) break;
        end
        if (cyc >= 3000) begin
            errors++;
            $display("FAIL timeout: got %0d words pending, expected 0", expq.size());
        end
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{0,  2, 1'b0, 1'b0, 16, 32'h0000_0000};  // empty message
        tbl[1] = '{3,  0, 1'b0, 1'b0, 16, 32'h0000_0018};  // "abc"
        tbl[2] = '{56, 1, 1'b0, 1'b0, 32, 32'h0000_01c0};  // NIST 56-byte
        tbl[3] = '{3,  0, 1'b0, 1'b1, 16, 32'h0000_0018};  // "abc" with backpressure
        tbl[4] = '{5,  2, 1'b1, 1'b0, 16, 32'h0000_0028};  // partial beat, junk bytes
        tbl[5] = '{55, 2, 1'b1, 1'b1, 16, 32'h0000_01b8};  // marker in word 13 byte 3
        tbl[6] = '{52, 2, 1'b1, 1'b0, 16, 32'h0000_01a0};  // full tlast beat, MARK at 13
        tbl[7] = '{60, 2, 1'b0, 1'b0, 32, 32'h0000_01e0};  // marker at word 15
        tbl[8] = '{64, 2, 1'b1, 1'b1, 32, 32'h0000_0200};  // MARK opens second block
        tbl[9] = '{62, 2, 1'b1, 1'b0, 32, 32'h0000_01f0};  // partial marker in word 15

        // Reset state
        #3;
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'h0);
        chk("rst_tlast",  32'(m_axis_tlast),  32'h0);
        chk("rst_tdata",  m_axis_tdata,       32'h0);
        chk("rst_sready", 32'(s_axis_tready), 32'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        foreach (tbl[i]) begin
            res_n.delete();
            res_last.delete();
            add_msg(tbl[i].len, tbl[i].kind, tbl[i].junk);
            run(tbl[i].bp, 0);
            vectors++;
            if (res_n.size() != 1) begin
                errors++;
                $display("FAIL msg_count[%0d]: got %0d messages, expected 1", i, res_n.size());
            end else begin
                chk($sformatf("nwords[%0d]", i), 32'(res_n[0]), 32'(tbl[i].exp_nwords));
                chk($sformatf("lenlo[%0d]", i), res_last[0], tbl[i].exp_lenlo);
            end
            @(negedge clk);
            #1;
            chk($sformatf("idle[%0d]", i), 32'(m_axis_tvalid), 32'h0);
        end

        // Reset after 5 beats of a 148-byte message, then "abc".
        res_n.delete();
        res_last.delete();
        add_msg(148, 2, 1'b0);
        run(1'b0, 5);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst_tvalid", 32'(m_axis_tvalid), 32'h0);
        chk("midrst_tdata",  m_axis_tdata,       32'h0);
        chk("midrst_tlast",  32'(m_axis_tlast),  32'h0);
        chk("midrst_sready", 32'(s_axis_tready), 32'h0);
        beats.delete();
        expq.delete();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        add_msg(3, 0, 1'b0);
        run(1'b0, 0);
        vectors++;
        if (res_n.size() != 1) begin
            errors++;
            $display("FAIL post_rst_count: got %0d messages, expected 1", res_n.size());
        end else begin
            chk("post_rst_nwords", 32'(res_n[0]), 32'd16);
            chk("post_rst_lenlo",  res_last[0],   32'h0000_0018);
        end

        // Back-to-back: 148 bytes then "abc" with no idle cycle between them.
        res_n.delete();
        res_last.delete();
        add_msg(148, 2, 1'b0);
        add_msg(3, 0, 1'b0);
        run(1'b0, 0);
        vectors++;
        if (res_n.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d messages, expected 2", res_n.size());
        end else begin
            chk("b2b_nwords0", 32'(res_n[0]), 32'd48);
            chk("b2b_lenlo0",  res_last[0],   32'h0000_04a0);
            chk("b2b_nwords1", 32'(res_n[1]), 32'd16);
            chk("b2b_lenlo1",  res_last[1],   32'h0000_0018);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
